// File: rtl/fp_normalize_round.sv
// fp_normalize_round -- post-add normalize / round-to-nearest-even / pack
// stage of the single-precision FPU.
//
// Two-stage pipeline:
//   stage 1: normalize the extended mantissa. A carry shifts it right by 1;
//            otherwise a leading-zero count shifts it left. The exponent is
//            adjusted to match.
//   stage 2: round to nearest-even on G/R/S, classify, and pack a binary32.
// Non-OK input classes (NAN/INF/NUL) skip the arithmetic. They still pass
// through both stages, so every result has the same latency.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_vld / in_rdy     upstream handshake (in_rdy = advance enable)
//   in_cls              upstream class: 00 OK, 01 NAN, 10 INF, 11 NUL
//   in_sign             result sign
//   in_exp  [EXP_W]     signed biased exponent of the hidden-bit position
//   in_mant [MANT_W]    {carry, hidden, frac[22:0], G, R, S}
//   result  [32]        packed binary32
//   state   [2]         status code of result (same encoding as in_cls)
//   res_vld / res_rdy   downstream handshake
//   inexact             only when FPN_INEXACT_FLAG_EN is defined: set when
//                       the result differs from the exact value
//
// Optional feature macro: FPN_INEXACT_FLAG_EN

module fp_normalize_round #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [1:0]        in_cls,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic [31:0]       result,
  output logic [1:0]        state,
  output logic              res_vld,
  input  logic              res_rdy
`ifdef FPN_INEXACT_FLAG_EN
  ,
  output logic              inexact
`endif
);

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_NAN = 2'b01,
    ST_INF = 2'b10,
    ST_NUL = 2'b11
  } st_e;

  localparam int NW   = MANT_W - 1;       // normalized: hidden..sticky
  localparam int SIGW = NW - 3;           // hidden + fraction bits
  localparam int LZW  = $clog2(NW + 1);
  // Two extra exponent bits: +1 from the carry shift, +1 from the rounding
  // carry. Neither can wrap for any legal in_exp.
  localparam int EW   = EXP_W + 2;

  localparam logic signed [EW-1:0] EXP_INF  = EW'(255);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic w_en;
  assign w_en   = !res_vld || res_rdy;
  assign in_rdy = w_en;

  // ---------------------------------------------------------------- stage 1
  logic [LZW-1:0]       w_lzc;
  logic                 w_found;
  logic [NW-1:0]        w_norm;
  logic signed [EW-1:0] w_exp_in;
  logic signed [EW-1:0] w_exp1;
  logic                 w_zero;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (in_mant[i]) w_found = 1'b1;
        else            w_lzc   = w_lzc + LZW'(1);
      end
    end
    w_exp_in = EW'($signed(in_exp));
    w_zero   = (in_mant == '0);
    if (in_mant[MANT_W-1]) begin
      // The bit shifted out below the sticky position folds into sticky.
      w_norm = {in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
      w_exp1 = w_exp_in + EW'(1);
    end else begin
      w_norm = in_mant[NW-1:0] << w_lzc;
      w_exp1 = w_exp_in - EW'(w_lzc);
    end
  end

  logic                 r1_vld;
  logic [1:0]           r1_cls;
  logic                 r1_sign;
  logic                 r1_zero;
  logic signed [EW-1:0] r1_exp;
  logic [NW-1:0]        r1_mant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_cls  <= ST_NUL;
      r1_sign <= 1'b0;
      r1_zero <= 1'b0;
      r1_exp  <= '0;
      r1_mant <= '0;
    end else if (w_en) begin
      r1_vld <= in_vld;
      if (in_vld) begin
        r1_cls  <= in_cls;
        r1_sign <= in_sign;
        r1_zero <= w_zero;
        r1_exp  <= w_exp1;
        r1_mant <= w_norm;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic                 w_g, w_r, w_s, w_rup;
  logic [SIGW:0]        w_sig;
  logic [SIGW-2:0]      w_frac;
  logic signed [EW-1:0] w_exp2;
  logic                 w_ovf, w_uf;
  logic [31:0]          w_res;
  logic [1:0]           w_st;

  always_comb begin
    w_g    = r1_mant[2];
    w_r    = r1_mant[1];
    w_s    = r1_mant[0];
    w_rup  = w_g && (w_r || w_s || r1_mant[3]);
    w_sig  = {1'b0, r1_mant[NW-1:3]} + {{SIGW{1'b0}}, w_rup};
    // A carry out of the significand means it rounded up to 2.0.
    if (w_sig[SIGW]) begin
      w_frac = '0;
      w_exp2 = r1_exp + EW'(1);
    end else begin
      w_frac = w_sig[SIGW-2:0];
      w_exp2 = r1_exp;
    end
    w_ovf = (w_exp2 >= EXP_INF);
    w_uf  = (w_exp2 <= EXP_ZERO);

    w_res = {r1_sign, 31'h0};
    w_st  = ST_NUL;
    case (r1_cls)
      ST_NAN: begin w_res = 32'h7FC0_0000;            w_st = ST_NAN; end
      ST_INF: begin w_res = {r1_sign, 8'hFF, 23'h0};  w_st = ST_INF; end
      ST_NUL: begin w_res = {r1_sign, 31'h0};         w_st = ST_NUL; end
      default: begin
        if (r1_zero) begin
          w_res = {r1_sign, 31'h0};                   w_st = ST_NUL;
        end else if (w_ovf) begin
          w_res = {r1_sign, 8'hFF, 23'h0};            w_st = ST_INF;
        end else if (w_uf) begin
          // No subnormals: anything below the normal range flushes to zero.
          w_res = {r1_sign, 31'h0};                   w_st = ST_NUL;
        end else begin
          w_res = {r1_sign, w_exp2[7:0], w_frac};     w_st = ST_OK;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      result  <= '0;
      state   <= ST_NUL;
    end else if (w_en) begin
      res_vld <= r1_vld;
      if (r1_vld) begin
        result <= w_res;
        state  <= w_st;
      end
    end
  end

`ifdef FPN_INEXACT_FLAG_EN
  logic w_inx;

  always_comb begin
    w_inx = 1'b0;
    if (r1_cls == ST_OK && !r1_zero) begin
      if (w_ovf || w_uf) w_inx = 1'b1;
      else               w_inx = w_g || w_r || w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  inexact <= 1'b0;
    else if (w_en && r1_vld)  inexact <= w_inx;
  end
`endif

endmodule
